// File: rtl/fifo_sync.sv
// Single-clock FIFO with programmable thresholds, overflow/underflow pulses and
// selectable standard or first-word-fall-through read data.
module fifo_sync #(
   parameter int unsigned pDATA_WIDTH  = 8,
   parameter int unsigned pDEPTH       = 32,
   parameter int unsigned pFALLTHROUGH = 0,
   parameter int unsigned pFLOPS       = 1,
   parameter int unsigned pBRAM        = 0,
   parameter int unsigned pDISTRIBUTED = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            full_threshold_value,
   input  logic [31:0]            empty_threshold_value,
   input  logic                   wen,
   input  logic [pDATA_WIDTH-1:0] wdata,
   output logic                   full,
   output logic                   almost_full,
   output logic                   overflow,
   output logic                   full_threshold,
   input  logic                   ren,
   output logic [pDATA_WIDTH-1:0] rdata,
   output logic                   empty,
   output logic                   almost_empty,
   output logic                   underflow,
   output logic                   empty_threshold
);

   localparam int AW = $clog2(pDEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(pDEPTH);
   localparam logic [AW:0] AFULL_C = (AW+1)'(pDEPTH - 1);

   logic [AW-1:0]          wptr, rptr;
   logic [AW:0]            count;
   logic                   wr_acc, rd_acc;
   logic [pDATA_WIDTH-1:0] head;

   // A full FIFO drops writes even when a read frees a slot the same cycle,
   // and an empty one drops reads even when a write arrives.
   assign wr_acc = wen & ~full;
   assign rd_acc = ren & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + AW'(1);
         if (rd_acc) rptr <= rptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         overflow  <= wen & full;
         underflow <= ren & empty;
      end
   end

   assign full            = (count == DEPTH_C);
   assign almost_full     = (count >= AFULL_C);
   assign empty           = (count == '0);
   assign almost_empty    = (count <= (AW+1)'(1));
   assign full_threshold  = (32'(count) >= full_threshold_value);
   assign empty_threshold = (32'(count) <= empty_threshold_value);

   // Storage style only steers the synthesis mapping; timing is identical.
   if (pFLOPS != 0) begin : g_flops
      (* ram_style = "registers" *) logic [pDATA_WIDTH-1:0] mem [pDEPTH];
      always_ff @(posedge clk) if (wr_acc) mem[wptr] <= wdata;
      assign head = mem[rptr];
   end else if (pBRAM != 0) begin : g_bram
      (* ram_style = "block" *) logic [pDATA_WIDTH-1:0] mem [pDEPTH];
      always_ff @(posedge clk) if (wr_acc) mem[wptr] <= wdata;
      assign head = mem[rptr];
   end else begin : g_dist
      (* ram_style = "distributed" *) logic [pDATA_WIDTH-1:0] mem [pDEPTH];
      always_ff @(posedge clk) if (wr_acc) mem[wptr] <= wdata;
      assign head = mem[rptr];
   end

   if (pFALLTHROUGH != 0) begin : g_fwft
      // Masked while empty so reset and idle read back as zero.
      assign rdata = empty ? '0 : head;
   end else begin : g_std
      logic [pDATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)      rdata_q <= '0;
         else if (rd_acc) rdata_q <= head;
      end
      assign rdata = rdata_q;
   end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed + random scoreboard bench; a standard and an FWFT instance share stimulus.
module tb_fifo_sync;

   localparam int D = 32;

   logic        clk, rst_n, wen, ren;
   logic [7:0]  wdata;
   logic [31:0] ft_val, et_val;

   logic [7:0] rdata_s, rdata_f;
   logic full_s, afull_s, ov_s, fth_s, empty_s, aempty_s, uf_s, eth_s;
   logic full_f, afull_f, ov_f, fth_f, empty_f, aempty_f, uf_f, eth_f;

   fifo_sync #(.pDATA_WIDTH(8), .pDEPTH(D), .pFALLTHROUGH(0)) u_std (
      .clk(clk), .rst_n(rst_n),
      .full_threshold_value(ft_val), .empty_threshold_value(et_val),
      .wen(wen), .wdata(wdata),
      .full(full_s), .almost_full(afull_s), .overflow(ov_s), .full_threshold(fth_s),
      .ren(ren), .rdata(rdata_s),
      .empty(empty_s), .almost_empty(aempty_s), .underflow(uf_s), .empty_threshold(eth_s));

   fifo_sync #(.pDATA_WIDTH(8), .pDEPTH(D), .pFALLTHROUGH(1),
               .pFLOPS(0), .pBRAM(1), .pDISTRIBUTED(0)) u_fwft (
      .clk(clk), .rst_n(rst_n),
      .full_threshold_value(ft_val), .empty_threshold_value(et_val),
      .wen(wen), .wdata(wdata),
      .full(full_f), .almost_full(afull_f), .overflow(ov_f), .full_threshold(fth_f),
      .ren(ren), .rdata(rdata_f),
      .empty(empty_f), .almost_empty(aempty_f), .underflow(uf_f), .empty_threshold(eth_f));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] q[$];
   int         m_cnt = 0;
   logic       m_ov = 1'b0, m_uf = 1'b0;
   logic [7:0] m_rd_std = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags();
      logic [7:0] exp;
      exp = {m_cnt == D, m_cnt >= D-1, m_ov, m_cnt >= ft_val,
             m_cnt == 0, m_cnt <= 1,   m_uf, m_cnt <= et_val};
      chk("flags_std",  {full_s, afull_s, ov_s, fth_s, empty_s, aempty_s, uf_s, eth_s}, exp);
      chk("flags_fwft", {full_f, afull_f, ov_f, fth_f, empty_f, aempty_f, uf_f, eth_f}, exp);
   endtask

   // Entered and left at posedge+1; expectations come from the queue model.
   task automatic step(input logic w, input logic r, input logic [7:0] d);
      logic wacc, racc;
      wen = w; ren = r; wdata = d;
      if (m_cnt > 0) chk("fwft_head", rdata_f, q[0]);
      wacc = w && (m_cnt < D);
      racc = r && (m_cnt > 0);
      m_ov = w && (m_cnt == D);
      m_uf = r && (m_cnt == 0);
      if (racc) m_rd_std = q.pop_front();
      if (wacc) q.push_back(d);
      m_cnt = q.size();
      @(posedge clk); #1;
      wen = 1'b0; ren = 1'b0;
      chk("std_rdata", rdata_s, m_rd_std);
      chk_flags();
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      q.delete(); m_cnt = 0; m_ov = 1'b0; m_uf = 1'b0; m_rd_std = 8'h00;
      #1;
      chk_flags();
      chk("rst_rdata_std", rdata_s, 0);
      chk("rst_rdata_fwft", rdata_f, 0);
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
      ft_val = 32'd20; et_val = 32'd5;
      #12;
      chk_flags();
      chk("rst_rdata_std", rdata_s, 0);
      chk("rst_rdata_fwft", rdata_f, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Read on empty: underflow pulse, rdata untouched.
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 8'h00);

      // Fill 0x00..0x1F, then overflow, then write+read while full.
      for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'(i));
      step(1'b1, 1'b0, 8'hEE);
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h77);

      // Drain everything, extra read, then write+read while empty.
      while (m_cnt > 0) step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b1, 8'h33);

      // Steady state at count 10 across many pointer wraps.
      while (m_cnt < 10) step(1'b1, 1'b0, 8'(8'h40 + m_cnt));
      for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 8'(i + 8'h80));
      chk("steady_count", m_cnt, 10);

      // Reset with 17 entries stored; old data must vanish.
      while (m_cnt < 17) step(1'b1, 1'b0, 8'(8'hC0 + m_cnt));
      mid_reset();
      step(1'b1, 1'b0, 8'hA5);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      chk("post_rst_rdata", rdata_s, 8'hA5);

      // Random traffic with different thresholds.
      ft_val = 32'd8; et_val = 32'd12;
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      while (m_cnt > 0) step(1'b0, 1'b1, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
